// File: rtl/flg_match_seq.sv
// flg_match_seq: sparse act/wei flag matcher and compressed-buffer address sequencer.
// Latency: one cycle from word accept to first match beat, then one beat per cycle.
// Backpressure: out_rdy stalls the beat in place; in_rdy is combinational from out_rdy on the last beat.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_clr                synchronous clear of running bases, drops the word in flight
//   in_val/in_rdy         flag word handshake (in_act_flag, in_wei_flag; bit i = channel i)
//   out_val/out_rdy       match beat handshake
//   out_chn               channel index of the match
//   out_act_addr/wei_addr absolute addresses in the compressed act/wei buffers
//   out_last              last match of the current flag word
module flg_match_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int CHN_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_clr,
    input  logic                  in_val,
    output logic                  in_rdy,
    input  logic [DATA_WIDTH-1:0] in_act_flag,
    input  logic [DATA_WIDTH-1:0] in_wei_flag,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [CHN_WIDTH-1:0]  out_chn,
    output logic [ADDR_WIDTH-1:0] out_act_addr,
    output logic [ADDR_WIDTH-1:0] out_wei_addr,
    output logic                  out_last
);

    localparam int CNT_W = CHN_WIDTH + 1;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] act_r_q, act_r_d;
    logic [DATA_WIDTH-1:0] wei_r_q, wei_r_d;
    logic [DATA_WIDTH-1:0] pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] act_base_q, act_base_d;
    logic [ADDR_WIDTH-1:0] wei_base_q, wei_base_d;
    logic [ADDR_WIDTH-1:0] cur_act_base_q, cur_act_base_d;
    logic [ADDR_WIDTH-1:0] cur_wei_base_q, cur_wei_base_d;

    logic [DATA_WIDTH-1:0] low_bit;   // lowest set bit of pend, one-hot
    logic [DATA_WIDTH-1:0] below;     // channels strictly below the current match
    logic [CHN_WIDTH-1:0]  pos;
    logic                  out_hs;
    logic                  accept;

    // Popcount is sized to hold DATA_WIDTH, then resized to the address width;
    // the address sums are modulo 2^ADDR_WIDTH either way.
    function automatic logic [ADDR_WIDTH-1:0] popcnt(input logic [DATA_WIDTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return ADDR_WIDTH'(c);
    endfunction

    // Two's-complement trick isolates the lowest set bit; minus one gives the
    // mask of lower channels. Gated so an empty pend yields an all-zero mask.
    assign low_bit = pend_q & (~pend_q + DATA_WIDTH'(1));
    assign below   = (low_bit - DATA_WIDTH'(1)) & {DATA_WIDTH{|pend_q}};

    always_comb begin
        pos = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                pos = CHN_WIDTH'(i);
            end
        end
    end

    assign out_val      = (state_q == EMIT);
    assign out_chn      = pos;
    assign out_act_addr = cur_act_base_q + popcnt(act_r_q & below);
    assign out_wei_addr = cur_wei_base_q + popcnt(wei_r_q & below);
    assign out_last     = (|pend_q) && (pend_q == low_bit);

    assign out_hs = out_val && out_rdy;
    // A new word may enter on the cycle its predecessor's last beat leaves.
    assign in_rdy = !in_clr && ((state_q == IDLE) || (out_hs && out_last));
    assign accept = in_val && in_rdy;

    always_comb begin
        state_d        = state_q;
        act_r_d        = act_r_q;
        wei_r_d        = wei_r_q;
        pend_d         = pend_q;
        act_base_d     = act_base_q;
        wei_base_d     = wei_base_q;
        cur_act_base_d = cur_act_base_q;
        cur_wei_base_d = cur_wei_base_q;

        if (in_clr) begin
            act_base_d = '0;
            wei_base_d = '0;
            pend_d     = '0;
            state_d    = IDLE;
        end else if (accept) begin
            cur_act_base_d = act_base_q;
            cur_wei_base_d = wei_base_q;
            act_base_d     = act_base_q + popcnt(in_act_flag);
            wei_base_d     = wei_base_q + popcnt(in_wei_flag);
            act_r_d        = in_act_flag;
            wei_r_d        = in_wei_flag;
            pend_d         = in_act_flag & in_wei_flag;
            // Zero-match words only advance the bases.
            state_d        = (|(in_act_flag & in_wei_flag)) ? EMIT : IDLE;
        end else if (out_hs) begin
            pend_d = pend_q & ~low_bit;
            if (out_last) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            act_r_q        <= '0;
            wei_r_q        <= '0;
            pend_q         <= '0;
            act_base_q     <= '0;
            wei_base_q     <= '0;
            cur_act_base_q <= '0;
            cur_wei_base_q <= '0;
        end else begin
            state_q        <= state_d;
            act_r_q        <= act_r_d;
            wei_r_q        <= wei_r_d;
            pend_q         <= pend_d;
            act_base_q     <= act_base_d;
            wei_base_q     <= wei_base_d;
            cur_act_base_q <= cur_act_base_d;
            cur_wei_base_q <= cur_wei_base_d;
        end
    end

endmodule

// File: tb/tb_flg_match_seq.sv
`timescale 1ns/1ps
module tb_flg_match_seq;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_clr;
    logic          in_val;
    logic          in_rdy;
    logic [DW-1:0] in_act_flag;
    logic [DW-1:0] in_wei_flag;
    logic          out_val;
    logic          out_rdy;
    logic [CW-1:0] out_chn;
    logic [AW-1:0] out_act_addr;
    logic [AW-1:0] out_wei_addr;
    logic          out_last;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int chn;
        int act;
        int wei;
        bit last;
    } beat_t;

    beat_t exp_q[$];
    int    m_act_base;
    int    m_wei_base;

    flg_match_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_clr       (in_clr),
        .in_val       (in_val),
        .in_rdy       (in_rdy),
        .in_act_flag  (in_act_flag),
        .in_wei_flag  (in_wei_flag),
        .out_val      (out_val),
        .out_rdy      (out_rdy),
        .out_chn      (out_chn),
        .out_act_addr (out_act_addr),
        .out_wei_addr (out_wei_addr),
        .out_last     (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] obs();
        return {out_val, out_chn, out_act_addr, out_wei_addr, out_last};
    endfunction

    function automatic logic [20:0] mk(logic v, int chn, int act, int wei, logic last);
        return {v, 3'(chn), 8'(act), 8'(wei), last};
    endfunction

    function automatic string fmt(logic [20:0] x);
        return $sformatf("val=%0b chn=%0d act=%0h wei=%0h last=%0b",
                         x[20], x[19:17], x[16:9], x[8:1], x[0]);
    endfunction

    // Reference model: walk the channels in order, counting non-zeros seen so
    // far in each stream; every common non-zero becomes one expected beat.
    function automatic void model_accept(logic [DW-1:0] a, logic [DW-1:0] w);
        int    seen_a = 0;
        int    seen_w = 0;
        int    left   = 0;
        beat_t b;
        for (int ch = 0; ch < DW; ch++) if (a[ch] && w[ch]) left++;
        for (int ch = 0; ch < DW; ch++) begin
            if (a[ch] && w[ch]) begin
                left--;
                b.chn  = ch;
                b.act  = (m_act_base + seen_a) % (1 << AW);
                b.wei  = (m_wei_base + seen_w) % (1 << AW);
                b.last = (left == 0);
                exp_q.push_back(b);
            end
            if (a[ch]) seen_a++;
            if (w[ch]) seen_w++;
        end
        m_act_base = (m_act_base + seen_a) % (1 << AW);
        m_wei_base = (m_wei_base + seen_w) % (1 << AW);
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        m_act_base = 0;
        m_wei_base = 0;
    endfunction

    // Present one cycle of inputs just after the falling edge; observation
    // happens 1ns later, well clear of the next rising edge.
    task automatic drive(input logic clr, input logic val, input logic [DW-1:0] a,
                         input logic [DW-1:0] w, input logic ordy);
        @(negedge clk);
        in_clr      = clr;
        in_val      = val;
        in_act_flag = a;
        in_wei_flag = w;
        out_rdy     = ordy;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_clr = 1'b0; in_val = 1'b0; out_rdy = 1'b1;
        in_act_flag = '0; in_wei_flag = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (obs() !== mk(0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL reset_outputs: got %s, want %s", fmt(obs()), fmt(mk(0, 0, 0, 0, 0)));
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++; $display("FAIL reset_in_rdy: got %b, want 1", in_rdy);
        end
    endtask

    task automatic test_basic_match();
        drive(0, 1, 8'hB6, 8'h65, 1);
        checks++;
        if ({in_rdy, out_val} !== 2'b10) begin
            errors++; $display("FAIL basic_accept: got rdy=%b val=%b, want rdy=1 val=0", in_rdy, out_val);
        end
        drive(0, 1, 8'hFF, 8'h01, 1);
        checks++;
        if (obs() !== mk(1, 2, 1, 1, 0)) begin
            errors++; $display("FAIL basic_beat0: got %s, want %s", fmt(obs()), fmt(mk(1, 2, 1, 1, 0)));
        end
        checks++;
        if (in_rdy !== 1'b0) begin
            errors++; $display("FAIL basic_rdy_busy: got %b, want 0", in_rdy);
        end
    endtask

    task automatic test_back_to_back();
        drive(0, 1, 8'hFF, 8'h01, 1);
        checks++;
        if (obs() !== mk(1, 5, 3, 2, 1)) begin
            errors++; $display("FAIL b2b_beat1: got %s, want %s", fmt(obs()), fmt(mk(1, 5, 3, 2, 1)));
        end
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++; $display("FAIL b2b_rdy_last: got %b, want 1", in_rdy);
        end
        drive(0, 1, 8'h0F, 8'hF0, 1);
        checks++;
        if (obs() !== mk(1, 0, 5, 4, 1)) begin
            errors++; $display("FAIL b2b_next_word: got %s, want %s", fmt(obs()), fmt(mk(1, 0, 5, 4, 1)));
        end
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++; $display("FAIL b2b_rdy_zero: got %b, want 1", in_rdy);
        end
    endtask

    task automatic test_zero_match();
        drive(0, 1, 8'hFF, 8'hFF, 1);
        checks++;
        if ({in_rdy, out_val} !== 2'b10) begin
            errors++; $display("FAIL zero_no_beat: got rdy=%b val=%b, want rdy=1 val=0", in_rdy, out_val);
        end
    endtask

    // Bases are now 17/9; the all-ones word streams under a 1,0,0,1 ready pattern.
    task automatic test_stall();
        bit [3:0] pat = 4'b1001;
        int       k   = 0;
        int       cyc = 0;
        logic     r;
        while (k < 8 && cyc < 40) begin
            r = pat[cyc[1:0]];
            drive(0, 0, 8'h00, 8'h00, r);
            checks++;
            if (obs() !== mk(1, k, 17 + k, 9 + k, (k == 7))) begin
                errors++; $display("FAIL stall_beat%0d: got %s, want %s", k, fmt(obs()), fmt(mk(1, k, 17 + k, 9 + k, (k == 7))));
            end
            if (r) k++;
            cyc++;
        end
        checks++;
        if (k != 8) begin
            errors++; $display("FAIL stall_timeout: got %0d beats, want 8", k);
        end
        drive(0, 0, 8'h00, 8'h00, 1);
        checks++;
        if (out_val !== 1'b0) begin
            errors++; $display("FAIL stall_done: got val=%b, want 0", out_val);
        end
    endtask

    task automatic test_wrap();
        drive(1, 1, 8'hFF, 8'hFF, 1);
        checks++;
        if (in_rdy !== 1'b0) begin
            errors++; $display("FAIL clr_blocks_rdy: got %b, want 0", in_rdy);
        end
        // 31 x 8 + 6 = 0xFE on the act side, weight side stays 0.
        for (int i = 0; i < 32; i++) begin
            drive(0, 1, (i == 31) ? 8'h3F : 8'hFF, 8'h00, 1);
            checks++;
            if ({in_rdy, out_val} !== 2'b10) begin
                errors++; $display("FAIL wrap_fill%0d: got rdy=%b val=%b, want rdy=1 val=0", i, in_rdy, out_val);
            end
        end
        drive(0, 1, 8'h03, 8'h03, 1);
        drive(0, 1, 8'h01, 8'h01, 1);
        checks++;
        if (obs() !== mk(1, 0, 8'hFE, 0, 0)) begin
            errors++; $display("FAIL wrap_beat0: got %s, want %s", fmt(obs()), fmt(mk(1, 0, 8'hFE, 0, 0)));
        end
        drive(0, 1, 8'h01, 8'h01, 1);
        checks++;
        if (obs() !== mk(1, 1, 8'hFF, 1, 1)) begin
            errors++; $display("FAIL wrap_beat1: got %s, want %s", fmt(obs()), fmt(mk(1, 1, 8'hFF, 1, 1)));
        end
        drive(0, 0, 8'h00, 8'h00, 1);
        checks++;
        if (obs() !== mk(1, 0, 8'h00, 2, 1)) begin
            errors++; $display("FAIL wrap_base_zero: got %s, want %s", fmt(obs()), fmt(mk(1, 0, 8'h00, 2, 1)));
        end
    endtask

    // Bases are now 1/3.
    task automatic test_clear();
        drive(0, 1, 8'hFF, 8'hFF, 1);
        drive(0, 0, 8'h00, 8'h00, 1);
        checks++;
        if (obs() !== mk(1, 0, 1, 3, 0)) begin
            errors++; $display("FAIL clr_first_beat: got %s, want %s", fmt(obs()), fmt(mk(1, 0, 1, 3, 0)));
        end
        drive(1, 1, 8'h01, 8'h01, 0);
        checks++;
        if (in_rdy !== 1'b0) begin
            errors++; $display("FAIL clr_rdy: got %b, want 0", in_rdy);
        end
        drive(0, 1, 8'h01, 8'h01, 1);
        checks++;
        if ({in_rdy, out_val} !== 2'b10) begin
            errors++; $display("FAIL clr_dropped: got rdy=%b val=%b, want rdy=1 val=0", in_rdy, out_val);
        end
        drive(0, 0, 8'h00, 8'h00, 1);
        checks++;
        if (obs() !== mk(1, 0, 0, 0, 1)) begin
            errors++; $display("FAIL clr_new_word: got %s, want %s", fmt(obs()), fmt(mk(1, 0, 0, 0, 1)));
        end
    endtask

    task automatic test_async_reset();
        drive(0, 1, 8'hFF, 8'hFF, 1);
        drive(0, 0, 8'h00, 8'h00, 0);
        checks++;
        if (out_val !== 1'b1) begin
            errors++; $display("FAIL arst_pre: got val=%b, want 1", out_val);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (obs() !== mk(0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL arst_immediate: got %s, want %s", fmt(obs()), fmt(mk(0, 0, 0, 0, 0)));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 0, 8'h00, 8'h00, 1);
        checks++;
        if ({in_rdy, out_val} !== 2'b10) begin
            errors++; $display("FAIL arst_no_replay: got rdy=%b val=%b, want rdy=1 val=0", in_rdy, out_val);
        end
    endtask

    task automatic test_random();
        logic          clr, val, ordy, exp_rdy;
        logic [DW-1:0] a, w;
        beat_t         f;
        drive(1, 0, 8'h00, 8'h00, 1);
        model_clear();
        for (int c = 0; c < 600; c++) begin
            clr  = ($urandom_range(0, 40) == 0);
            val  = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                a = 8'($urandom) & 8'($urandom);
                w = 8'($urandom) & 8'($urandom);
            end else begin
                a = 8'($urandom);
                w = 8'($urandom);
            end
            drive(clr, val, a, w, ordy);
            exp_rdy = !clr && (exp_q.size() == 0 || (exp_q.size() == 1 && ordy));
            checks++;
            if (in_rdy !== exp_rdy) begin
                errors++; $display("FAIL rnd_in_rdy c=%0d: got %b, want %b", c, in_rdy, exp_rdy);
            end
            checks++;
            if (out_val !== (exp_q.size() != 0)) begin
                errors++; $display("FAIL rnd_out_val c=%0d: got %b, want %b", c, out_val, (exp_q.size() != 0));
            end
            if (exp_q.size() != 0) begin
                f = exp_q[0];
                checks++;
                if (obs() !== mk(1, f.chn, f.act, f.wei, f.last)) begin
                    errors++; $display("FAIL rnd_beat c=%0d: got %s, want %s", c, fmt(obs()), fmt(mk(1, f.chn, f.act, f.wei, f.last)));
                end
            end
            if (clr) begin
                model_clear();
            end else begin
                if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
                if (val && exp_rdy) model_accept(a, w);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_match();
        test_back_to_back();
        test_zero_match();
        test_stall();
        test_wrap();
        test_clear();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

endmodule

// File: doc/flg_match_seq.md
# flg_match_seq

Parametrised sparse-flag matcher and address sequencer for the PE datapath. It accepts one activation/weight non-zero flag word per handshake. For every channel where both flags are set, it emits one output beat with the channel index and the absolute addresses of that activation and that weight in their compressed buffers. Running base addresses carry across flag words. Output is elastic with full valid/ready backpressure, and back-to-back flag words incur no bubbles. It sits between the flag fetch stage and the compressed act/wei SRAM read ports.

## Interface
Parameters:
- DATA_WIDTH, 32, channels per flag word; power of 2, at least 4.
- ADDR_WIDTH, 12, width of compressed-buffer addresses; addresses wrap modulo 2^ADDR_WIDTH.
- CHN_WIDTH, log2(DATA_WIDTH), derived width of the channel index.

Ports:
- clk  in  1  single clock; all state is updated on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_clr  in  1  synchronous clear of running bases and abort of the current word.
- in_val  in  1  flag word valid.
- in_rdy  out  1  block can accept a flag word.
- in_act_flag  in  DATA_WIDTH  activation non-zero flags; bit i is channel i (LSB is ch0).
- in_wei_flag  in  DATA_WIDTH  weight non-zero flags; same bit order.
- out_val  out  1  match beat valid.
- out_rdy  in  1  consumer accepts the beat.
- out_chn  out  CHN_WIDTH  channel index of the match.
- out_act_addr  out  ADDR_WIDTH  absolute activation address.
- out_wei_addr  out  ADDR_WIDTH  absolute weight address.
- out_last  out  1  last match of the current flag word.

## Operation
- Registered state:
  - act_base and wei_base: running bases.
  - cur_act_base and cur_wei_base: bases of the word in flight.
  - act_r and wei_r: flags of the word in flight.
  - pend: remaining matches.
  - state: IDLE or EMIT.
- An accept occurs when in_val and in_rdy are both high.
- in_rdy = !in_clr && (state == IDLE || (out_val && out_rdy && out_last)). This path is combinational from out_rdy.
- On accept:
  - cur_act_base <= act_base and cur_wei_base <= wei_base.
  - act_base <= act_base + popcount(in_act_flag) and wei_base <= wei_base + popcount(in_wei_flag).
  - act_r and wei_r capture the input flags.
  - pend <= in_act_flag & in_wei_flag.
  - state <= EMIT if pend is non-zero, else IDLE. A zero-match word is consumed with no output beat; only the bases advance.
- In EMIT:
  - p = index of the lowest set bit of pend.
  - out_chn = p.
  - out_act_addr = cur_act_base + popcount(act_r & ((1<<p)-1)).
  - out_wei_addr = cur_wei_base + popcount(wei_r & ((1<<p)-1)).
  - out_last = (pend has exactly one bit set).
  - out_val = 1.
- On an output handshake: clear bit p of pend. If out_last and no accept occurs in the same cycle, state <= IDLE. If an accept occurs in the same cycle, load the new word as above.
- Outputs are held stable while out_val=1 and out_rdy=0.
- in_clr (priority over everything except rst):
  - act_base, wei_base and pend are set to 0; state <= IDLE.
  - No accept happens in that cycle.
  - Any partially emitted word is dropped.
- Arithmetic:
  - popcount results are DATA_WIDTH-bit-safe (CHN_WIDTH+1 bits), zero-extended to ADDR_WIDTH.
  - All additions are modulo 2^ADDR_WIDTH.
- Reset values:
  - state is IDLE; pend and all bases and flag registers are 0.
  - out_val=0, out_last=0, out_chn=0, out_act_addr=0, out_wei_addr=0.
  - in_rdy=1 after reset is released.

## Timing
- Latency from accept to first out_val: 1 cycle.
- Throughput: one match beat per cycle under out_rdy=1.
- The next word can be accepted in the same cycle as the last beat of the current word, so there is no bubble.
- Zero-match words are consumed at one per cycle while idle.
- A word with N matches occupies N cycles of output when out_rdy is held high.
- in_clr takes effect at the next edge: out_val=0 in the following cycle.
- Asynchronous reset mid-word: outputs return to their reset values immediately. No beat is replayed.

## Test plan
The bench uses DATA_WIDTH=8, ADDR_WIDTH=8, out_rdy=1 unless stated otherwise.
- Reset, then act=8'hB6 and wei=8'h65 -> beats (chn2, act1, wei1, last0) and (chn5, act3, wei2, last1). Bases then equal 5 and 4.
- Next word act=8'hFF and wei=8'h01, accepted on the last-beat cycle -> no bubble. Beat (chn0, act5, wei4, last1). Bases become 13 and 5.
- Word act=8'h0F and wei=8'hF0 (zero match) -> no beat, in_rdy stays 1, bases advance by 4 and 4.
- act=wei=8'hFF with out_rdy toggling 1,0,0,1,... -> 8 beats, chn0..7, each held stable while stalled. last is set only on chn7.
- Starting from act_base=8'hFE, act=wei=8'h03 -> beats with act addresses 8'hFE and 8'hFF. act_base wraps to 8'h00.
- Assert in_clr after the first beat of act=wei=8'hFF -> out_val=0 in the next cycle. A new word act=wei=8'h01 then yields (chn0, act0, wei0, last1).
